sd_bus_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single physical SD bus (CMD/DAT pins and shifter) between N requesters.

---
 rtl/sd_bus_arbiter_pkg.sv | 16 +
 rtl/sd_bus_arbiter_rr_pick.sv | 43 ++++
 rtl/sd_bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_sd_bus_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_bus_arbiter_pkg.sv
// Shared definitions for the SD host bus arbiter and its requester engines.
// Holds the arbiter state encoding and the default watchdog limit that the
// command engine also uses.
package sd_bus_arbiter_pkg;

  // Arbiter states; the encodings match the legacy 2-bit constants.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  // Default cycles an owner may hold the bus before a forced release.
  localparam int unsigned SD_TIMEOUT_MAX_DEFAULT = 50000;

endpackage

// File: rtl/sd_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: reports whether any request is set and
// the index of the first set request found scanning from rr_ptr upward with
// wrap-around. Also used by the DAT-line FIFO scheduler.
module rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0]   rot;
  logic [IDX_W-1:0] off;
  logic           found;
  logic [IDX_W:0] sum;

  // Rotate so bit 0 is the request at rr_ptr, then find the lowest set bit.
  always_comb begin
    rot   = N'({req, req} >> rr_ptr);
    off   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = IDX_W'(i);
      end
    end
  end

  // Map the rotated offset back to an absolute requester index.
  always_comb begin
    sum   = {1'b0, rr_ptr} + {1'b0, off};
    valid = |req;
    if (sum >= (IDX_W+1)'(N)) begin
      idx = IDX_W'(sum - (IDX_W+1)'(N));
    end else begin
      idx = IDX_W'(sum);
    end
  end

endmodule

// File: rtl/sd_bus_arbiter.sv
// Round-robin owner arbiter for the shared SD CMD/DAT bus.
// Grants one requester at a time, inserts a one-cycle turnaround after each
// release and drives `owner` as the pad/shift datapath mux select.
// Optional watchdog force-release: define SD_BUS_ARB_TIMEOUT_EN.
module sd_bus_arbiter
  import sd_bus_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned IDX_W       = 3,
  parameter int unsigned TIMEOUT_W   = 16,
  parameter int unsigned TIMEOUT_MAX = SD_TIMEOUT_MAX_DEFAULT
) (
  input  logic             C,
  input  logic             R,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic [IDX_W-1:0] owner,
  output logic             timeout
);

  // Elaboration-time parameter sanity checks.
  if (N_REQ < 2 || N_REQ > 8 || (1 << IDX_W) < N_REQ) begin : g_bad_req_cfg
    $error("sd_bus_arbiter: N_REQ must be 2..8 and fit in IDX_W bits");
  end
  if (TIMEOUT_MAX < 1 || TIMEOUT_MAX > (1 << TIMEOUT_W) - 1) begin : g_bad_tmo_cfg
    $error("sd_bus_arbiter: TIMEOUT_MAX must be 1..2**TIMEOUT_W-1");
  end

  arb_state_t       state, state_n;
  logic [N_REQ-1:0] gnt_n;
  logic [IDX_W-1:0] owner_n;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_n;
  logic [IDX_W-1:0] rr_next;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             own_req;
  logic             own_done;
  logic             wdog_expire;
  logic             timeout_n;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  // In GRANT, gnt is the one-hot of owner, so masking with gnt selects the
  // owner's req/done bits without a variable-width index.
  always_comb begin
    own_req  = |(req & gnt);
    own_done = |(done & gnt);
    rr_next  = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
  end

`ifdef SD_BUS_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wdog, wdog_n;

  // Watchdog expiry compare against the configured limit.
  always_comb begin
    wdog_expire = (wdog == TIMEOUT_W'(TIMEOUT_MAX - 1));
  end
`else
  // No watchdog: GRANT ends only on done or abort.
  always_comb begin
    wdog_expire = 1'b0;
  end
`endif

  // Next-state and next-register values; done/abort take priority over expiry.
  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    owner_n   = owner;
    rr_ptr_n  = rr_ptr;
    timeout_n = 1'b0;
`ifdef SD_BUS_ARB_TIMEOUT_EN
    wdog_n    = wdog;
`endif
    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_n = ARB_GRANT;
          gnt_n   = N_REQ'(1) << pick_idx;
          owner_n = pick_idx;
`ifdef SD_BUS_ARB_TIMEOUT_EN
          wdog_n  = '0;
`endif
        end
      end
      ARB_GRANT: begin
        if (own_done || !own_req || wdog_expire) begin
          state_n   = ARB_RELEASE;
          gnt_n     = '0;
          rr_ptr_n  = rr_next;
          // Only reachable here without done/abort when the watchdog fired.
          timeout_n = own_req && !own_done;
        end else begin
`ifdef SD_BUS_ARB_TIMEOUT_EN
          wdog_n = wdog + 1'b1;
`endif
        end
      end
      ARB_RELEASE: begin
        state_n = ARB_IDLE;
      end
      default: begin
        state_n = ARB_IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge C) begin
    if (R) begin
      state  <= ARB_IDLE;
      gnt    <= '0;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_n;
      gnt    <= gnt_n;
      owner  <= owner_n;
      rr_ptr <= rr_ptr_n;
    end
  end

`ifdef SD_BUS_ARB_TIMEOUT_EN
  // Watchdog counter and one-cycle forced-release pulse.
  always_ff @(posedge C) begin
    if (R) begin
      wdog    <= '0;
      timeout <= 1'b0;
    end else begin
      wdog    <= wdog_n;
      timeout <= timeout_n;
    end
  end
`else
  // Forced release is not built; timeout_n is constant zero here.
  always_comb begin
    timeout = timeout_n;
  end
`endif

  // Bus is owned or turning around in every state but IDLE.
  always_comb begin
    busy = (state != ARB_IDLE);
  end

endmodule

// File: tb/tb_sd_bus_arbiter.sv
// Self-checking bench for sd_bus_arbiter (3 requesters, watchdog limit 8).
// Expectations come from an integer-level model of the arbitration rules.
module tb_sd_bus_arbiter;

  localparam int N    = 3;
  localparam int TMAX = 8;

  logic       C;
  logic       R;
  logic [2:0] req;
  logic [2:0] done;
  logic [2:0] gnt;
  logic       busy;
  logic [1:0] owner;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: owner index or -1, turnaround flag, pointer, last owner.
  int m_own;
  int m_rel;
  int m_ptr;
  int m_last;
  int m_held;
  int m_tmo;

  int order[4];
  int waited;

  sd_bus_arbiter #(
    .N_REQ       (3),
    .IDX_W       (2),
    .TIMEOUT_W   (4),
    .TIMEOUT_MAX (TMAX)
  ) dut (
    .C       (C),
    .R       (R),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .busy    (busy),
    .owner   (owner),
    .timeout (timeout)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_update();
    bit expire;
    if (R) begin
      m_own = -1; m_rel = 0; m_ptr = 0; m_last = 0; m_held = 0; m_tmo = 0;
    end else begin
      m_tmo = 0;
      if (m_own >= 0) begin
`ifdef SD_BUS_ARB_TIMEOUT_EN
        expire = (m_held == TMAX - 1);
`else
        expire = 1'b0;
`endif
        if (done[m_own] || !req[m_own] || expire) begin
          m_tmo = (!done[m_own] && req[m_own]) ? 1 : 0;
          m_ptr = (m_own + 1) % N;
          m_own = -1;
          m_rel = 1;
        end else begin
          m_held++;
        end
      end else if (m_rel != 0) begin
        m_rel = 0;
      end else begin
        for (int i = 0; i < N; i++) begin
          int k;
          k = (m_ptr + i) % N;
          if (m_own < 0 && req[k]) begin
            m_own = k; m_last = k; m_held = 0;
          end
        end
      end
    end
  endtask

  task automatic compare();
    logic [2:0] exp_gnt;
    exp_gnt = (m_own >= 0) ? (3'b001 << m_own) : 3'b000;
    check("gnt", {29'b0, gnt}, {29'b0, exp_gnt});
    check("busy", {31'b0, busy}, (m_own >= 0 || m_rel != 0) ? 1 : 0);
    check("owner", {30'b0, owner}, m_last);
    check("timeout", {31'b0, timeout}, m_tmo);
    check("onehot", {31'b0, $onehot0(gnt)}, 1);
  endtask

  task automatic step();
    @(posedge C);
    model_update();
    #1;
    compare();
  endtask

  task automatic do_reset();
    R = 1'b1;
    step();
    R = 1'b0;
  endtask

  task automatic wait_grant(output int steps);
    steps = 0;
    while (gnt == 3'b000 && steps < 10) begin
      step();
      steps++;
    end
    check("grant_wait", {31'b0, gnt != 3'b000}, 1);
  endtask

  initial begin
    R = 1'b1; req = 3'b011; done = 3'b000;
    m_own = -1; m_rel = 0; m_ptr = 0; m_last = 0; m_held = 0; m_tmo = 0;

    // Reset with requests held, then first grant one edge after reset drops.
    repeat (3) step();
    check("rst_gnt", {29'b0, gnt}, 0);
    R = 1'b0;
    step();
    check("first_gnt", {29'b0, gnt}, 32'b001);
    check("first_owner", {30'b0, owner}, 0);

    // done[0] -> two zero-grant cycles -> requester 1.
    step(); step();
    done = 3'b001;
    step();
    done = 3'b000;
    check("rel_gnt", {29'b0, gnt}, 0);
    step();
    check("turn_gnt", {29'b0, gnt}, 0);
    step();
    check("regrant", {29'b0, gnt}, 32'b010);
    done = 3'b010;
    step();
    done = 3'b000;

    // Abort by dropping req, then done while idle is ignored.
    do_reset();
    req = 3'b001;
    step(); step(); step();
    req = 3'b000;
    step();
    check("abort_gnt", {29'b0, gnt}, 0);
    done = 3'b010;
    step();
    done = 3'b000;
    step(); step();
    check("abort_idle", {29'b0, gnt}, 0);
    check("abort_busy", {31'b0, busy}, 0);

    // Grant order with all requesting and done each grant.
    do_reset();
    req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_grant(waited);
      order[i] = int'(owner);
      done = gnt;
      step();
      done = 3'b000;
    end
    check("order0", order[0], 0);
    check("order1", order[1], 1);
    check("order2", order[2], 2);
    check("order3", order[3], 0);
    wait_grant(waited);
    check("mid_owner", {30'b0, owner}, 1);
    R = 1'b1;
    step();
    R = 1'b0;
    check("mid_rst_gnt", {29'b0, gnt}, 0);
    check("mid_rst_tmo", {31'b0, timeout}, 0);
    step();
    check("mid_restart", {29'b0, gnt}, 32'b001);

`ifdef SD_BUS_ARB_TIMEOUT_EN
    // Watchdog expiry exactly TMAX cycles after grant.
    do_reset();
    req = 3'b001;
    step();
    waited = 0;
    while (timeout !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    check("tmo_cycles", waited, TMAX);
    check("tmo_gnt", {29'b0, gnt}, 0);
    // done coinciding with expiry wins: no pulse.
    do_reset();
    req = 3'b001;
    step();
    repeat (TMAX - 1) step();
    done = 3'b001;
    step();
    done = 3'b000;
    check("done_wins_tmo", {31'b0, timeout}, 0);
    check("done_wins_gnt", {29'b0, gnt}, 0);
`endif

    // Long hold of one requester.
    do_reset();
    req = 3'b010;
    repeat (2000) step();
`ifndef SD_BUS_ARB_TIMEOUT_EN
    check("hold_gnt", {29'b0, gnt}, 32'b010);
`endif

    // Randomized traffic.
    do_reset();
    req = 3'b000;
    for (int c = 0; c < 3000; c++) begin
      done = 3'b000;
      R = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!req[i]) begin
          if ($urandom_range(2) == 0) req[i] = 1'b1;
        end else if (gnt[i]) begin
          int r;
          r = $urandom_range(19);
          if (r < 3) done[i] = 1'b1;
          else if (r == 3) req[i] = 1'b0;
        end else if ($urandom_range(39) == 0) begin
          req[i] = 1'b0;
        end
      end
      if ($urandom_range(9) == 0) done = done | (3'b001 << $urandom_range(2));
      if ($urandom_range(299) == 0) R = 1'b1;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
